// File: rtl/spi_defs.sv
// Shared encodings and constants for the SPI RDID responder.
package spi_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CMD    = 2'b01,
    RESP   = 2'b10,
    IGNORE = 2'b11
  } state_e;

  localparam logic [7:0] RDID_OPCODE = 8'h9F;
  localparam int         ID_BYTE_W   = 8;
  localparam int         RESP_LEN    = 24;

endpackage

// File: rtl/sync.sv
// Two-flop synchroniser for a single asynchronous level, with selectable reset value.
module sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_rdid_responder.sv
// Mode-0 SPI target answering RDID with a 3-byte JEDEC ID; SPI pins oversampled on clk.
module spi_rdid_responder
  import spi_defs::*;
#(
  parameter logic [7:0] RDID_CMD = RDID_OPCODE,
  parameter logic [7:0] MFG_ID   = 8'h20,
  parameter logic [7:0] MEM_TYPE = 8'h20,
  parameter logic [7:0] MEM_CAP  = 8'h16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SPICLK,
  input  logic       SPIMOSI,
  input  logic       chip_select,
  output logic       SPIMISO,
  output logic       miso_oe,
  output logic [7:0] cmd_byte,
  output logic       cmd_valid,
  output logic       rdid_done
);

  localparam logic [RESP_LEN-1:0] ID_WORD = {MFG_ID, MEM_TYPE, MEM_CAP};

  logic sclk_s, mosi_s, csn_s;

  sync #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .reset(reset), .d_i(SPICLK),      .q_o(sclk_s));
  sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .reset(reset), .d_i(SPIMOSI),     .q_o(mosi_s));
  sync #(.RST_VAL(1'b1)) u_sync_csn  (.clk(clk), .reset(reset), .d_i(chip_select), .q_o(csn_s));

  logic sclk_q;
  logic sclk_rise, sclk_fall;

  assign sclk_rise =  sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s &  sclk_q;

  state_e                state_q, state_d;
  logic [2:0]            bitcnt_q, bitcnt_d;
  logic [4:0]            rcnt_q, rcnt_d;
  logic [7:0]            cmd_sr_q, cmd_sr_d;
  logic [RESP_LEN-1:0]   id_sr_q, id_sr_d;
  logic                  skip_q, skip_d;
  logic                  miso_q, miso_d;
  logic                  oe_q, oe_d;
  logic [7:0]            cmd_byte_q, cmd_byte_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  done_q, done_d;
  logic [7:0]            opcode;

  assign opcode = {cmd_sr_q[6:0], mosi_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q      <= 1'b0;
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      rcnt_q      <= '0;
      cmd_sr_q    <= '0;
      id_sr_q     <= '0;
      skip_q      <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      cmd_byte_q  <= 8'h00;
      cmd_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sclk_q      <= sclk_s;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rcnt_q      <= rcnt_d;
      cmd_sr_q    <= cmd_sr_d;
      id_sr_q     <= id_sr_d;
      skip_q      <= skip_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    rcnt_d      = rcnt_q;
    cmd_sr_d    = cmd_sr_q;
    id_sr_d     = id_sr_q;
    skip_d      = skip_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    done_d      = 1'b0;
    if (csn_s) begin
      // Deselect beats any edge seen in the same cycle, so aborts emit no pulses.
      state_d  = IDLE;
      bitcnt_d = '0;
      rcnt_d   = '0;
      skip_d   = 1'b0;
      miso_d   = 1'b0;
      oe_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = CMD;
          bitcnt_d = '0;
          rcnt_d   = '0;
        end
        CMD: begin
          if (sclk_rise) begin
            cmd_sr_d = opcode;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'(ID_BYTE_W - 1)) begin
              cmd_byte_d  = opcode;
              cmd_valid_d = 1'b1;
              if (opcode == RDID_CMD) begin
                id_sr_d = ID_WORD;
                miso_d  = ID_WORD[RESP_LEN-1];
                oe_d    = 1'b1;
                skip_d  = 1'b1;
                rcnt_d  = '0;
                state_d = RESP;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        RESP: begin
          // Rotating rather than shifting means the register is back at the
          // ID after 24 bits, so the wrap needs no separate reload path.
          if (sclk_fall) begin
            if (skip_q) begin
              skip_d = 1'b0;
            end else begin
              id_sr_d = {id_sr_q[RESP_LEN-2:0], id_sr_q[RESP_LEN-1]};
              miso_d  = id_sr_q[RESP_LEN-2];
            end
          end else if (sclk_rise) begin
            if (rcnt_q == 5'(RESP_LEN - 1)) begin
              rcnt_d = '0;
              done_d = 1'b1;
            end else begin
              rcnt_d = rcnt_q + 5'd1;
            end
          end
        end
        IGNORE: begin
          miso_d = 1'b0;
          oe_d   = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign SPIMISO   = miso_q;
  assign miso_oe   = oe_q;
  assign cmd_byte  = cmd_byte_q;
  assign cmd_valid = cmd_valid_q;
  assign rdid_done = done_q;

endmodule

// File: tb/tb_spi_rdid_responder.sv
// Scoreboard bench: a clk/16 mode-0 master drives opcodes and checks returned bytes and pulses.
module tb_spi_rdid_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       SPICLK, SPIMOSI, chip_select;
  logic       SPIMISO, miso_oe, cmd_valid, rdid_done;
  logic [7:0] cmd_byte;

  spi_rdid_responder dut (
    .clk(clk), .reset(reset), .SPICLK(SPICLK), .SPIMOSI(SPIMOSI),
    .chip_select(chip_select), .SPIMISO(SPIMISO), .miso_oe(miso_oe),
    .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .rdid_done(rdid_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [7:0] exp_cmd_q[$];
  logic [7:0] exp_rx_q[$];
  int   done_cnt  = 0;
  int   valid_cnt = 0;
  logic oe_seen   = 1'b0;
  logic miso_seen = 1'b0;

  // Pulse/cmd monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_valid) begin
        valid_cnt++;
        if (exp_cmd_q.size() == 0) chk("cmd_unexpected", 32'(cmd_byte), 32'hFFFF_FFFF);
        else                       chk("cmd_byte", 32'(cmd_byte), 32'(exp_cmd_q.pop_front()));
      end
      if (rdid_done) done_cnt++;
      if (miso_oe)   oe_seen   = 1'b1;
      if (SPIMISO)   miso_seen = 1'b1;
    end
  end

  // One mode-0 bit: data set while SCLK low, MISO sampled at the rising edge.
  task automatic spi_bit(input logic mosi, output logic miso);
    SPIMOSI = mosi;
    repeat (8) @(negedge clk);
    miso   = SPIMISO;
    SPICLK = 1'b1;
    repeat (8) @(negedge clk);
    SPICLK = 1'b0;
  endtask

  task automatic sel();
    oe_seen   = 1'b0;
    miso_seen = 1'b0;
    chip_select = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic desel();
    repeat (8) @(negedge clk);
    chip_select = 1'b1;
    SPIMOSI     = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_op(input logic [7:0] op);
    logic b;
    exp_cmd_q.push_back(op);
    for (int i = 7; i >= 0; i--) spi_bit(op[i], b);
  endtask

  task automatic resp(input int nbits);
    logic       b;
    logic [7:0] rx;
    rx = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      spi_bit(1'b0, b);
      rx = {rx[6:0], b};
      if (k % 8 == 7) begin
        if (exp_rx_q.size() == 0) chk("rx_unexpected", 32'(rx), 32'hFFFF_FFFF);
        else                      chk("rx_byte", 32'(rx), 32'(exp_rx_q.pop_front()));
      end
    end
  endtask

  task automatic push_id(input int reps);
    for (int r = 0; r < reps; r++) begin
      exp_rx_q.push_back(8'h20);
      exp_rx_q.push_back(8'h20);
      exp_rx_q.push_back(8'h16);
    end
  endtask

  task automatic rdid_xfer(input int reps);
    int d0, v0;
    d0 = done_cnt;
    v0 = valid_cnt;
    push_id(reps);
    sel();
    send_op(8'h9F);
    resp(24 * reps);
    desel();
    chk("rdid_done_count", 32'(done_cnt - d0), 32'(reps));
    chk("cmd_valid_count", 32'(valid_cnt - v0), 32'd1);
    chk("oe_after_desel", 32'(miso_oe), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    reset = 1'b1; SPICLK = 1'b0; SPIMOSI = 1'b0; chip_select = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    // 1: reset state
    chk("rst_miso", 32'(SPIMISO), 32'd0);
    chk("rst_oe", 32'(miso_oe), 32'd0);
    chk("rst_cmd_byte", 32'(cmd_byte), 32'h00);
    chk("rst_pulses", 32'(valid_cnt + done_cnt), 32'd0);

    // 2: single ID read
    rdid_xfer(1);
    // 3: wrapped double read
    rdid_xfer(2);

    // 4: non-RDID opcode: line stays low and undriven
    d0 = done_cnt;
    exp_rx_q.push_back(8'h00); exp_rx_q.push_back(8'h00); exp_rx_q.push_back(8'h00);
    sel();
    send_op(8'h03);
    resp(24);
    desel();
    chk("ign_cmd_byte", 32'(cmd_byte), 32'h03);
    chk("ign_oe_seen", 32'(oe_seen), 32'd0);
    chk("ign_miso_seen", 32'(miso_seen), 32'd0);
    chk("ign_done", 32'(done_cnt - d0), 32'd0);

    // 5: abort after 12 response bits, then full read
    d0 = done_cnt;
    exp_rx_q.push_back(8'h20);
    sel();
    send_op(8'h9F);
    resp(12);
    desel();
    chk("abort_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_oe", 32'(miso_oe), 32'd0);
    chk("abort_miso", 32'(SPIMISO), 32'd0);
    rdid_xfer(1);

    // 6: reset during RESP
    d0 = done_cnt;
    exp_rx_q.push_back(8'h20);
    sel();
    send_op(8'h9F);
    resp(12);
    chk("pre_rst_oe", 32'(miso_oe), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_state", 32'(dut.state_q), 32'(spi_defs::IDLE));
    chk("rst_mid_oe", 32'(miso_oe), 32'd0);
    chk("rst_mid_miso", 32'(SPIMISO), 32'd0);
    reset = 1'b0;
    desel();
    chk("rst_mid_done", 32'(done_cnt - d0), 32'd0);
    rdid_xfer(1);

    chk("cmd_queue_empty", 32'(exp_cmd_q.size()), 32'd0);
    chk("rx_queue_empty", 32'(exp_rx_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
